// File: rtl/mem_request_scheduler.sv
// -----------------------------------------------------------------------------
// mem_request_scheduler
//   Shares one downstream memory-request port among NUM_PORTS sources. Each
//   source pushes into a private FIFO. A burst-limited round-robin arbiter
//   pops one head per load cycle into a registered output stage.
//
// Ports
//   clk          in   clock, all state on the rising edge
//   reset_n      in   synchronous active-low reset
//   in_valid     in   [NUM_PORTS] per-port request valid
//   in_ready     out  [NUM_PORTS] per-port FIFO can accept (registered)
//   in_request   in   mem_request_t [NUM_PORTS] per-port payload
//   out_valid    out  output request valid (registered)
//   out_ready    in   downstream accepts
//   out_request  out  granted request (registered)
//   out_port_id  out  source port of out_request (registered)
// -----------------------------------------------------------------------------
package mem_request_scheduler_pkg;
  typedef struct packed {
    logic [31:0] page_addr;
    logic [15:0] access_count;
  } mem_request_t;
endpackage

module mem_request_scheduler
  import mem_request_scheduler_pkg::*;
#(
  parameter int NUM_PORTS  = 4,
  parameter int FIFO_DEPTH = 2,
  parameter int QUANTUM    = 4
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [NUM_PORTS-1:0]         in_valid,
  output logic [NUM_PORTS-1:0]         in_ready,
  input  mem_request_t                 in_request [NUM_PORTS],
  output logic                         out_valid,
  input  logic                         out_ready,
  output mem_request_t                 out_request,
  output logic [$clog2(NUM_PORTS)-1:0] out_port_id
);

  localparam int PIDW = $clog2(NUM_PORTS);
  localparam int PTRW = $clog2(FIFO_DEPTH);
  localparam int CNTW = PTRW + 1;
  localparam int BW   = $clog2(QUANTUM) + 1;
  localparam logic [CNTW-1:0] DEPTH_C     = CNTW'(FIFO_DEPTH);
  localparam logic [BW-1:0]   QUANTUM_C   = BW'(QUANTUM);
  localparam logic [PIDW-1:0] LAST_PORT_C = PIDW'(NUM_PORTS - 1);

  // FIFO storage and bookkeeping
  mem_request_t         mem_q    [NUM_PORTS][FIFO_DEPTH];
  logic [PTRW-1:0]      wr_ptr_q [NUM_PORTS];
  logic [PTRW-1:0]      rd_ptr_q [NUM_PORTS];
  logic [CNTW-1:0]      count_q  [NUM_PORTS];
  logic [CNTW-1:0]      count_d  [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_ready_q, in_ready_d;
  logic [NUM_PORTS-1:0] nonempty_s, others_s, push_s, pop_s;

  // Arbiter state
  logic [PIDW-1:0] cur_q, cur_d;
  logic [BW-1:0]   burst_q, burst_d;
  logic [PIDW-1:0] scan_sel_s, sel_s;
  logic            grant_s, can_load_s;

  // Output stage
  logic            out_valid_q;
  mem_request_t    out_request_q;
  logic [PIDW-1:0] out_port_id_q;
  mem_request_t    head_s;

  // Port index reached by stepping 'offset' positions past 'base' with wrap
  function automatic logic [PIDW-1:0] wrap_port(input logic [PIDW-1:0] base, input int offset);
    return PIDW'((int'(base) + offset) % NUM_PORTS);
  endfunction

  assign can_load_s = !out_valid_q || out_ready;
  assign head_s     = mem_q[sel_s][rd_ptr_q[sel_s]];

  // Occupancy flags and accepted pushes; a full FIFO ignores in_valid
  always_comb begin
    nonempty_s = '0;
    push_s     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      nonempty_s[i] = (count_q[i] != {CNTW{1'b0}});
      push_s[i]     = in_valid[i] & in_ready_q[i];
    end
  end

  // Non-empty ports other than the current owner
  always_comb begin
    others_s        = nonempty_s;
    others_s[cur_q] = 1'b0;
  end

  // Round-robin scan from cur+1; walking backwards lets the nearest hit win
  always_comb begin
    scan_sel_s = cur_q;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      scan_sel_s = nonempty_s[wrap_port(cur_q, k)] ? wrap_port(cur_q, k) : scan_sel_s;
    end
  end

  // Grant decision: keep cur within its quantum, or past it when nobody else waits
  always_comb begin
    grant_s = 1'b0;
    sel_s   = cur_q;
    cur_d   = cur_q;
    burst_d = burst_q;
    if (can_load_s && (|nonempty_s)) begin
      grant_s = 1'b1;
      if (nonempty_s[cur_q] && (burst_q < QUANTUM_C)) begin
        burst_d = burst_q + BW'(1'b1);
      end else if (nonempty_s[cur_q] && !(|others_s)) begin
        burst_d = QUANTUM_C;
      end else begin
        sel_s   = scan_sel_s;
        burst_d = BW'(1'b1);
      end
      cur_d = sel_s;
    end else begin
      grant_s = 1'b0;
    end
  end

  // Pops, next counts and next in_ready (derived from next count, so registered)
  always_comb begin
    pop_s      = '0;
    in_ready_d = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      pop_s[i]      = grant_s && (sel_s == PIDW'(i));
      count_d[i]    = count_q[i] + CNTW'(push_s[i]) - CNTW'(pop_s[i]);
      in_ready_d[i] = (count_d[i] < DEPTH_C);
    end
  end

  // FIFO pointers, counts and in_ready register
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        count_q[i]  <= '0;
      end
      in_ready_q <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (push_s[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PTRW'(1'b1);
        if (pop_s[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PTRW'(1'b1);
        count_q[i] <= count_d[i];
      end
      in_ready_q <= in_ready_d;
    end
  end

  // FIFO payload storage; contents are meaningless while count is zero
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (push_s[i]) mem_q[i][wr_ptr_q[i]] <= in_request[i];
    end
  end

  // Arbiter state; cur starts at the last port so port 0 is scanned first
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      cur_q   <= LAST_PORT_C;
      burst_q <= '0;
    end else begin
      cur_q   <= cur_d;
      burst_q <= burst_d;
    end
  end

  // Output stage; payload holds when nothing is loaded
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      out_valid_q   <= 1'b0;
      out_request_q <= '0;
      out_port_id_q <= '0;
    end else if (can_load_s) begin
      out_valid_q <= grant_s;
      if (grant_s) begin
        out_request_q <= head_s;
        out_port_id_q <= sel_s;
      end
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = out_valid_q;
  assign out_request = out_request_q;
  assign out_port_id = out_port_id_q;

endmodule

// File: tb/tb_mem_request_scheduler.sv
// -----------------------------------------------------------------------------
// tb_mem_request_scheduler
//   Directed bench for mem_request_scheduler (NUM_PORTS=4, FIFO_DEPTH=2,
//   QUANTUM=2). Each task drives one scenario and compares against
//   hand-computed cycle-by-cycle expectations. Outputs are sampled 1 time
//   unit after the rising edge; inputs are changed at the same point.
// -----------------------------------------------------------------------------
module tb_mem_request_scheduler;
  import mem_request_scheduler_pkg::*;

  localparam int NP = 4;
  localparam int FD = 2;
  localparam int QT = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NP-1:0]         in_valid;
  logic [NP-1:0]         in_ready;
  mem_request_t          in_request [NP];
  logic                  out_valid;
  logic                  out_ready;
  mem_request_t          out_request;
  logic [$clog2(NP)-1:0] out_port_id;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_request_scheduler #(
    .NUM_PORTS (NP),
    .FIFO_DEPTH(FD),
    .QUANTUM   (QT)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_request (in_request),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_request(out_request),
    .out_port_id(out_port_id)
  );

  // Payload encodes a scenario tag, the source port and a sequence number
  function automatic mem_request_t mk(input logic [7:0] tag, input int p, input int seq);
    mem_request_t r;
    r.page_addr    = {tag, 8'(p), 16'(seq)};
    r.access_count = 16'(seq * 7 + p + 1);
    return r;
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs;
    in_valid = '0;
    for (int p = 0; p < NP; p++) in_request[p] = '0;
  endtask

  task automatic test_reset;
    reset_n   = 1'b0;
    out_ready = 1'b1;
    clear_inputs();
    repeat (3) tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL reset_in_ready got %b want 0000", in_ready); end
    checks++; if (out_port_id !== 2'd0) begin errors++; $display("FAIL reset_port_id got %0d want 0", out_port_id); end
    checks++; if (out_request !== 48'h0) begin errors++; $display("FAIL reset_request got %h want 0", out_request); end
    reset_n = 1'b1;
    tick();
    checks++; if (in_ready !== 4'b1111) begin errors++; $display("FAIL release_in_ready got %b want 1111", in_ready); end
    for (int c = 0; c < 3; c++) begin
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL idle_out_valid cycle %0d got %0b want 0", c, out_valid); end
      tick();
    end
  endtask

  task automatic test_single_latency;
    mem_request_t a;
    a = mk(8'hA1, 2, 0);
    in_valid[2]   = 1'b1;
    in_request[2] = a;
    tick();
    in_valid = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_no_bypass got %0b want 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL lat_valid got %0b want 1", out_valid); end
    checks++; if (out_request !== a) begin errors++; $display("FAIL lat_request got %h want %h", out_request, a); end
    checks++; if (out_port_id !== 2'd2) begin errors++; $display("FAIL lat_port got %0d want 2", out_port_id); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL lat_drop got %0b want 0", out_valid); end
  endtask

  task automatic test_round_robin;
    int pat [8] = '{0, 0, 1, 1, 0, 0, 1, 1};
    int push_seq [2] = '{0, 0};
    int out_seq  [2] = '{0, 0};
    logic [NP-1:0] acc;
    logic drained;
    int pp;
    out_ready = 1'b1;
    for (int c = 0; c < 9; c++) begin
      for (int p = 0; p < 2; p++) begin
        in_valid[p]   = 1'b1;
        in_request[p] = mk(8'h52, p, push_seq[p]);
      end
      acc = in_ready;
      tick();
      for (int p = 0; p < 2; p++) if (acc[p]) push_seq[p]++;
      if (c == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rr_first_idle got %0b want 0", out_valid); end
      end else begin
        pp = pat[c-1];
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rr_valid step %0d got %0b want 1", c, out_valid); end
        checks++; if (out_port_id !== 2'(pp)) begin errors++; $display("FAIL rr_port step %0d got %0d want %0d", c, out_port_id, pp); end
        checks++; if (out_request !== mk(8'h52, pp, out_seq[pp])) begin
          errors++; $display("FAIL rr_request step %0d got %h want %h", c, out_request, mk(8'h52, pp, out_seq[pp]));
        end
        out_seq[pp]++;
      end
    end
    in_valid = '0;
    drained = 1'b0;
    for (int c = 0; c < 8 && !drained; c++) begin
      tick();
      if (out_valid !== 1'b1) begin
        drained = 1'b1;
      end else begin
        pp = int'(out_port_id);
        checks++; if (pp > 1) begin errors++; $display("FAIL rr_drain_port got %0d want 0 or 1", pp); end
        else begin
          checks++; if (out_request !== mk(8'h52, pp, out_seq[pp])) begin
            errors++; $display("FAIL rr_drain_request got %h want %h", out_request, mk(8'h52, pp, out_seq[pp]));
          end
          out_seq[pp]++;
        end
      end
    end
    checks++; if (!drained) begin errors++; $display("FAIL rr_drain_timeout got busy want idle"); end
    for (int p = 0; p < 2; p++) begin
      checks++; if (out_seq[p] != push_seq[p]) begin errors++; $display("FAIL rr_count port %0d got %0d want %0d", p, out_seq[p], push_seq[p]); end
    end
  endtask

  task automatic test_back_to_back;
    out_ready = 1'b1;
    checks++; if (in_ready !== 4'b1111) begin errors++; $display("FAIL b2b_start_ready got %b want 1111", in_ready); end
    for (int k = 0; k < 6; k++) begin
      checks++; if (in_ready[3] !== 1'b1) begin errors++; $display("FAIL b2b_ready push %0d got %0b want 1", k, in_ready[3]); end
      in_valid[3]   = 1'b1;
      in_request[3] = mk(8'h33, 3, k);
      tick();
      if (k == 0) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_first got %0b want 0", out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1 || out_port_id !== 2'd3) begin
          errors++; $display("FAIL b2b_out k %0d got valid %0b port %0d want valid 1 port 3", k, out_valid, out_port_id);
        end
        checks++; if (out_request !== mk(8'h33, 3, k - 1)) begin
          errors++; $display("FAIL b2b_request k %0d got %h want %h", k, out_request, mk(8'h33, 3, k - 1));
        end
      end
    end
    in_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_request !== mk(8'h33, 3, 5)) begin
      errors++; $display("FAIL b2b_last got valid %0b req %h want valid 1 req %h", out_valid, out_request, mk(8'h33, 3, 5));
    end
    checks++; if (dut.burst_q !== 2'(QT)) begin errors++; $display("FAIL b2b_burst got %0d want %0d", dut.burst_q, QT); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_end got %0b want 0", out_valid); end
  endtask

  task automatic test_stall;
    int ep [8] = '{0, 1, 1, 2, 2, 3, 3, 0};
    int es [8] = '{1, 0, 1, 0, 1, 0, 1, 2};
    mem_request_t r;
    r = mk(8'h5A, 0, 0);
    out_ready = 1'b0;
    for (int e = 1; e <= 6; e++) begin
      for (int p = 0; p < NP; p++) begin
        in_valid[p]   = 1'b1;
        in_request[p] = mk(8'h5A, p, (e <= 3) ? e - 1 : 16'hEE);
      end
      tick();
      if (e == 1) begin
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL stall_first got %0b want 0", out_valid); end
      end else begin
        checks++; if (out_valid !== 1'b1 || out_port_id !== 2'd0 || out_request !== r) begin
          errors++; $display("FAIL stall_hold e %0d got v %0b p %0d r %h want v 1 p 0 r %h", e, out_valid, out_port_id, out_request, r);
        end
      end
      if (e == 2) begin
        checks++; if (in_ready !== 4'b0001) begin errors++; $display("FAIL stall_ready_e2 got %b want 0001", in_ready); end
      end else if (e >= 3) begin
        checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL stall_full e %0d got %b want 0000", e, in_ready); end
      end
    end
    in_valid  = '0;
    out_ready = 1'b1;
    for (int j = 0; j < 8; j++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_port_id !== 2'(ep[j])) begin
        errors++; $display("FAIL drain_port j %0d got v %0b p %0d want v 1 p %0d", j, out_valid, out_port_id, ep[j]);
      end
      checks++; if (out_request !== mk(8'h5A, ep[j], es[j])) begin
        errors++; $display("FAIL drain_request j %0d got %h want %h", j, out_request, mk(8'h5A, ep[j], es[j]));
      end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_end got %0b want 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    out_ready = 1'b0;
    for (int e = 0; e < 3; e++) begin
      for (int p = 0; p < NP; p++) begin
        in_valid[p]   = 1'b1;
        in_request[p] = mk(8'hD0, p, e);
      end
      tick();
    end
    checks++; if (out_valid !== 1'b1 || in_ready !== 4'b0000) begin
      errors++; $display("FAIL mid_pre got v %0b rdy %b want v 1 rdy 0000", out_valid, in_ready);
    end
    reset_n  = 1'b0;
    in_valid = '0;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", out_valid); end
    checks++; if (in_ready !== 4'b0000) begin errors++; $display("FAIL mid_ready got %b want 0000", in_ready); end
    checks++; if (out_request !== 48'h0) begin errors++; $display("FAIL mid_request got %h want 0", out_request); end
    for (int p = 0; p < NP; p++) begin
      checks++; if (dut.count_q[p] !== 2'd0) begin errors++; $display("FAIL mid_count port %0d got %0d want 0", p, dut.count_q[p]); end
    end
    reset_n   = 1'b1;
    out_ready = 1'b1;
    tick();
    checks++; if (in_ready !== 4'b1111 || out_valid !== 1'b0) begin
      errors++; $display("FAIL mid_release got rdy %b v %0b want rdy 1111 v 0", in_ready, out_valid);
    end
    for (int p = 0; p < 3; p++) begin
      in_valid[p]   = 1'b1;
      in_request[p] = mk(8'hE0, p, 0);
    end
    tick();
    in_valid = '0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_no_leftover got %0b want 0", out_valid); end
    for (int j = 0; j < 3; j++) begin
      tick();
      checks++; if (out_valid !== 1'b1 || out_port_id !== 2'(j) || out_request !== mk(8'hE0, j, 0)) begin
        errors++; $display("FAIL mid_grant j %0d got v %0b p %0d r %h want v 1 p %0d r %h",
                           j, out_valid, out_port_id, out_request, j, mk(8'hE0, j, 0));
      end
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL mid_end got %0b want 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_single_latency();
    test_round_robin();
    test_back_to_back();
    test_stall();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
